// File: rtl/bram_access_arbiter.sv
// Shares the single-port user BRAM between the Wishbone slave path and a user
// valid/ready port. Each access holds EN for DELAY cycles, then acks/responds once.
module bram_access_arbiter #(
  parameter int DELAY = 10,
  parameter int AW    = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [3:0]    req_sel_i,
  input  logic [AW-1:0] req_adr_i,
  input  logic [31:0]   req_dat_i,
  output logic          rsp_valid_o,
  output logic [31:0]   rsp_dat_o,
  output logic          bram_en_o,
  output logic [3:0]    bram_we_o,
  output logic [AW-1:0] bram_adr_o,
  output logic [31:0]   bram_di_o,
  input  logic [31:0]   bram_do_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [3:0] LAST_CNT = 4'(DELAY - 1);

  state_t        state_q, state_d;
  logic [3:0]    count_q;
  logic          last_q;   // 1 = user port held the most recent grant
  logic          gnt_q;    // 1 = current access belongs to the user port
  logic          we_q;
  logic          abort_q;
  logic [3:0]    sel_q;
  logic [AW-1:0] adr_q;
  logic [31:0]   dat_q;
  logic [31:0]   rdata_q;
  logic          wb_req, usr_req, pick_usr;

  assign wb_req   = wbs_cyc_i & wbs_stb_i;
  assign usr_req  = req_valid_i;
  // On a conflict the user wins only if Wishbone had the previous grant.
  assign pick_usr = usr_req & (~wb_req | ~last_q);

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    wbs_ack_o   = 1'b0;
    wbs_dat_o   = '0;
    rsp_valid_o = 1'b0;
    rsp_dat_o   = '0;
    bram_en_o   = 1'b0;
    bram_we_o   = '0;
    bram_adr_o  = '0;
    bram_di_o   = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = pick_usr;
        if (wb_req | usr_req) state_d = ACCESS;
      end
      ACCESS: begin
        bram_en_o  = 1'b1;
        bram_adr_o = adr_q;
        bram_di_o  = dat_q;
        // Write strobes only on the first cycle so each write lands exactly once.
        if (count_q == 4'd0) bram_we_o = sel_q & {4{we_q}};
        if (count_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        wbs_ack_o   = ~gnt_q & ~abort_q;
        wbs_dat_o   = (~gnt_q & ~abort_q) ? rdata_q : '0;
        rsp_valid_o = gnt_q;
        rsp_dat_o   = gnt_q ? rdata_q : '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (wb_req | usr_req) begin
            gnt_q   <= pick_usr;
            last_q  <= pick_usr;
            count_q <= '0;
            abort_q <= 1'b0;
            we_q    <= pick_usr ? req_we_i  : wbs_we_i;
            sel_q   <= pick_usr ? req_sel_i : wbs_sel_i;
            adr_q   <= pick_usr ? req_adr_i : wbs_adr_i;
            dat_q   <= pick_usr ? req_dat_i : wbs_dat_i;
          end
        end
        ACCESS: begin
          count_q <= count_q + 4'd1;
          // A dropped cycle still finishes the BRAM access but loses its ack.
          if (!gnt_q && !wbs_cyc_i) abort_q <= 1'b1;
          if (count_q == LAST_CNT) rdata_q <= bram_do_i;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_access_arbiter.sv
// Bench for bram_access_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level timing/memory model.
module tb_bram_access_arbiter;
  localparam int DELAY = 10;
  localparam int AW    = 32;
  localparam logic [31:0] BASE = 32'h3800_0000;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [AW-1:0] wbs_adr_i;
  logic [31:0]   wbs_dat_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          req_valid_i, req_ready_o, req_we_i;
  logic [3:0]    req_sel_i;
  logic [AW-1:0] req_adr_i;
  logic [31:0]   req_dat_i;
  logic          rsp_valid_o;
  logic [31:0]   rsp_dat_o;
  logic          bram_en_o;
  logic [3:0]    bram_we_o;
  logic [AW-1:0] bram_adr_o;
  logic [31:0]   bram_di_o;
  logic [31:0]   bram_do_i = '0;

  always #5 wb_clk_i = ~wb_clk_i;

  bram_access_arbiter #(.DELAY(DELAY), .AW(AW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_sel_i(req_sel_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o),
    .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_adr_o(bram_adr_o),
    .bram_di_o(bram_di_o), .bram_do_i(bram_do_i)
  );

  // BRAM: 16 words, byte writes, one-cycle read latency.
  logic [31:0] bram [16] = '{default: '0};
  always @(posedge wb_clk_i) begin
    if (bram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bram_we_o[b]) bram[bram_adr_o[5:2]][b*8 +: 8] <= bram_di_o[b*8 +: 8];
      bram_do_i <= bram[bram_adr_o[5:2]];
    end
  end

  int checks = 0, failures = 0;

  // Reference: word memory plus one in-flight transaction with fixed timing.
  logic [31:0] ref_mem [16];
  int          cyc_n, free_at, g_cyc;
  bit          last_usr, in_flight, g_usr, g_abort, g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_adr, g_di, g_data;

  // Observations taken from the DUT.
  int          ack_cyc, rsp_cyc, ready_cyc, we_cyc, nserved;
  bit          obs_en;
  logic [31:0] last_wb_dat, last_rsp_dat, gseq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic step();
    logic        wb_req, exp_en, exp_ready, exp_ack, exp_rsp, in_acc;
    logic [3:0]  exp_we;
    logic [31:0] mask;
    bit          saw_ack, saw_ready;
    #2;
    wb_req    = wbs_cyc_i & wbs_stb_i;
    exp_ready = 1'b0;
    if (!wb_rst_i && cyc_n >= free_at && (wb_req || req_valid_i)) begin
      g_usr   = (wb_req && req_valid_i) ? !last_usr : req_valid_i;
      g_we    = g_usr ? req_we_i  : wbs_we_i;
      g_sel   = g_usr ? req_sel_i : wbs_sel_i;
      g_adr   = g_usr ? req_adr_i : wbs_adr_i;
      g_di    = g_usr ? req_dat_i : wbs_dat_i;
      mask    = {{8{g_sel[3]}}, {8{g_sel[2]}}, {8{g_sel[1]}}, {8{g_sel[0]}}};
      if (g_we) ref_mem[g_adr[5:2]] = (ref_mem[g_adr[5:2]] & ~mask) | (g_di & mask);
      g_data    = ref_mem[g_adr[5:2]];
      g_cyc     = cyc_n;
      g_abort   = 1'b0;
      in_flight = 1'b1;
      free_at   = cyc_n + DELAY + 2;
      last_usr  = g_usr;
      exp_ready = g_usr;
    end
    in_acc  = in_flight && cyc_n >= g_cyc + 1 && cyc_n <= g_cyc + DELAY;
    exp_en  = in_acc;
    exp_we  = (in_flight && cyc_n == g_cyc + 1 && g_we) ? g_sel : 4'h0;
    exp_ack = in_flight && cyc_n == g_cyc + DELAY + 1 && !g_usr && !g_abort;
    exp_rsp = in_flight && cyc_n == g_cyc + DELAY + 1 && g_usr;

    chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
    chk("bram_en",   32'(bram_en_o),   32'(exp_en));
    chk("bram_we",   32'(bram_we_o),   32'(exp_we));
    chk("bram_adr",  bram_adr_o,       exp_en ? g_adr : 32'h0);
    chk("bram_di",   bram_di_o,        exp_en ? g_di  : 32'h0);
    chk("wbs_ack",   32'(wbs_ack_o),   32'(exp_ack));
    chk("wbs_dat",   wbs_dat_o,        exp_ack ? g_data : 32'h0);
    chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp));
    chk("rsp_dat",   rsp_dat_o,        exp_rsp ? g_data : 32'h0);

    saw_ack   = wbs_ack_o;
    saw_ready = req_ready_o;
    obs_en    = bram_en_o;
    if (bram_we_o != 4'h0) we_cyc = cyc_n;
    if (req_ready_o) ready_cyc = cyc_n;
    if (wbs_ack_o) begin
      ack_cyc = cyc_n; last_wb_dat = wbs_dat_o;
      gseq = {gseq[30:0], 1'b0}; nserved++;
    end
    if (rsp_valid_o) begin
      rsp_cyc = cyc_n; last_rsp_dat = rsp_dat_o;
      gseq = {gseq[30:0], 1'b1}; nserved++;
    end

    if (in_acc && !g_usr && !wbs_cyc_i) g_abort = 1'b1;
    if (wb_rst_i) begin
      in_flight = 1'b0; free_at = cyc_n + 1; last_usr = 1'b1;
    end else if (in_flight && cyc_n == g_cyc + DELAY + 1) begin
      in_flight = 1'b0;
    end

    @(posedge wb_clk_i); #1;
    cyc_n++;
    if (saw_ready) req_valid_i = 1'b0;
    if (saw_ack) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
  endtask

  task automatic wb_go(input bit we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
  endtask

  task automatic usr_go(input bit we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    req_valid_i = 1'b1; req_we_i = we; req_sel_i = sel; req_adr_i = adr; req_dat_i = dat;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((wbs_stb_i || req_valid_i || in_flight) && n < limit) begin
      step(); n++;
    end
    chk("drain_bound", 32'(n < limit), 32'h1);
  endtask

  initial begin
    int s, nw, nu, r;
    logic [31:0] a, d;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    wb_rst_i = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    req_valid_i = 0; req_we_i = 0; req_sel_i = 0; req_adr_i = 0; req_dat_i = 0;
    ack_cyc = -1; rsp_cyc = -1; ready_cyc = -1; we_cyc = -1; nserved = 0; gseq = '0;
    cyc_n = 0; free_at = 0; g_cyc = 0; last_usr = 1'b1; in_flight = 1'b0;
    g_usr = 0; g_abort = 0; g_we = 0; g_sel = 0; g_adr = 0; g_di = 0; g_data = 0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_en",    32'(bram_en_o),   32'h0);
    chk("rst_we",    32'(bram_we_o),   32'h0);
    chk("rst_ack",   32'(wbs_ack_o),   32'h0);
    chk("rst_rsp",   32'(rsp_valid_o), 32'h0);
    chk("rst_ready", 32'(req_ready_o), 32'h0);
    chk("rst_adr",   bram_adr_o,       32'h0);
    wb_rst_i = 1'b0;

    // Wishbone full-word write, then read back.
    wb_go(1, 4'hF, BASE + 32'h10, 32'h1234_5678); s = cyc_n;
    drain(50);
    chk("wr_we_cycle",  32'(we_cyc - s),  32'd1);
    chk("wr_ack_cycle", 32'(ack_cyc - s), 32'(DELAY + 1));
    wb_go(0, 4'hF, BASE + 32'h10, 32'h0);
    drain(50);
    chk("rd_data", last_wb_dat, 32'h1234_5678);

    // Byte-enable merge.
    wb_go(1, 4'h5, BASE + 32'h10, 32'hAABB_CCDD);
    drain(50);
    wb_go(0, 4'hF, BASE + 32'h10, 32'h0);
    drain(50);
    chk("sel_merge", last_wb_dat, 32'h12BB_56DD);

    // Simultaneous requests straight out of reset: Wishbone first.
    wb_rst_i = 1'b1; step(); wb_rst_i = 1'b0;
    wb_go(0, 4'hF, BASE, 32'h0);
    usr_go(0, 4'hF, BASE + 32'h4, 32'h0); s = cyc_n;
    drain(60);
    chk("sim_ack_cycle",   32'(ack_cyc - s),   32'd11);
    chk("sim_ready_cycle", 32'(ready_cyc - s), 32'd12);
    chk("sim_rsp_cycle",   32'(rsp_cyc - s),   32'd23);

    // Continuous contention: service must alternate.
    gseq = '0; nserved = 0; nw = 0; nu = 0; s = 0;
    while (nserved < 6 && s < 200) begin
      if (!wbs_stb_i && nw < 3) begin wb_go(0, 4'hF, BASE + 32'(nw * 4), 32'h0); nw++; end
      if (!req_valid_i && nu < 3) begin usr_go(1, 4'hF, BASE + 32'h20 + 32'(nu * 4), $urandom); nu++; end
      step(); s++;
    end
    drain(60);
    chk("fair_count", 32'(nserved), 32'd6);
    chk("fair_order", gseq & 32'h3F, 32'h15);

    // Wishbone abort during ACCESS: write lands, no ack.
    ack_cyc = -1;
    wb_go(1, 4'hF, BASE + 32'h30, 32'hCAFE_F00D);
    step(); step(); step();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    drain(50);
    chk("abort_no_ack", 32'(ack_cyc), 32'hFFFF_FFFF);
    wb_go(0, 4'hF, BASE + 32'h30, 32'h0);
    drain(50);
    chk("abort_wr_lands", last_wb_dat, 32'hCAFE_F00D);

    // Reset in ACCESS cycle 5.
    ack_cyc = -1; rsp_cyc = -1;
    wb_go(0, 4'hF, BASE + 32'h10, 32'h0);
    repeat (5) step();
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    step();
    wb_rst_i = 1'b0;
    step();
    chk("rst_en_drop", 32'(obs_en), 32'h0);
    repeat (DELAY + 2) step();
    chk("rst_no_ack", 32'(ack_cyc), 32'hFFFF_FFFF);
    chk("rst_no_rsp", 32'(rsp_cyc), 32'hFFFF_FFFF);
    wb_go(1, 4'h3, BASE + 32'h8, 32'h0BAD_BEEF); s = cyc_n;
    drain(50);
    chk("post_rst_latency", 32'(ack_cyc - s), 32'(DELAY + 1));

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 3);
      if (r[0]) begin
        a = BASE + 32'($urandom_range(0, 15) * 4); d = $urandom;
        wb_go(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, d);
      end
      if (r[1]) begin
        a = BASE + 32'($urandom_range(0, 15) * 4); d = $urandom;
        usr_go(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, d);
      end
      drain(60);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
